// File: rtl/rest_serial_ncc_if.sv
// rtl/rest_serial_ncc_if.sv - start/done handshake and operand/result bundle for the bit-serial adder
interface rest_serial_ncc_if #(
    parameter int WIDTH = 4
);
    logic             init;
    logic             op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] R;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             busy;
    logic             done;

    modport master (
        output init, op, A, B,
        input  R, cout, ovf, zero, busy, done
    );

    modport slave (
        input  init, op, A, B,
        output R, cout, ovf, zero, busy, done
    );
endinterface

// File: rtl/rest_serial_ncc.sv
// rtl/rest_serial_ncc.sv - bit-serial add/subtract, one full-adder cell, LSB first, WIDTH cycles per op
module rest_serial_ncc #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    rest_serial_ncc_if.slave   bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             op_r;
    logic             c;
    logic [CW-1:0]    cnt;
    logic [WIDTH-2:0] shadow;
    logic [WIDTH-1:0] r_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;
    logic             busy_q;
    logic             done_q;

    // Operands are shifted right each bit-cycle so the cell always sees bit 0.
    logic             bi;
    logic             s_bit;
    logic             c_next;
    logic [WIDTH-1:0] res_next;

    assign bi       = b_r[0] ^ op_r;
    assign s_bit    = a_r[0] ^ bi ^ c;
    assign c_next   = (a_r[0] & bi) | (a_r[0] & c) | (bi & c);
    assign res_next = {s_bit, shadow};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_r    <= '0;
            b_r    <= '0;
            op_r   <= 1'b0;
            c      <= 1'b0;
            cnt    <= '0;
            shadow <= '0;
            r_q    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.init) begin
                        a_r    <= bus.A;
                        b_r    <= bus.B;
                        op_r   <= bus.op;
                        c      <= bus.op;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_r    <= a_r >> 1;
                    b_r    <= b_r >> 1;
                    c      <= c_next;
                    shadow <= res_next[WIDTH-1:1];
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        // c here is the carry into the MSB, c_next the carry out of it.
                        r_q    <= res_next;
                        cout_q <= c_next ^ op_r;
                        ovf_q  <= c ^ c_next;
                        zero_q <= (res_next == '0);
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.R    = r_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
    assign bus.zero = zero_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule
